// File: rtl/mario_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mario_pkg
//  Description : Shared types and widths for the Mario gameplay-stats block:
//                game-flow state encoding, counter widths, coins-per-1UP.
//  Revision    : 1.0 - initial release
// ============================================================================
package mario_pkg;

   // Game-flow states
   typedef enum logic [1:0] {
      PLAY       = 2'd0,
      DYING      = 2'd1,
      LEVEL_DONE = 2'd2,
      GAME_OVER  = 2'd3
   } state_t;

   localparam int LIVES_W        = 4;
   localparam int LEVEL_W        = 4;
   localparam int COINS_W        = 12;
   localparam int COINS_PER_LIFE = 100;

   // Saturating clamp of an integer configuration value to a ceiling
   function automatic int clamp_max(input int value, input int ceiling);
      return (value > ceiling) ? ceiling : value;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mario_hold_timer.sv
`default_nettype none
// ============================================================================
//  Module      : mario_hold_timer
//  Description : Pause timer for the DYING / LEVEL_DONE states. 'start' clears
//                and arms the count; 'expired' is high for exactly one cycle
//                when the count reaches HOLD_CYCLES-1, after which the timer
//                disarms itself. 'clear' disarms without expiring.
//  Revision    : 1.0 - initial release
// ============================================================================
module mario_hold_timer #(
   parameter int HOLD_CYCLES = 65000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic clear,
   output logic expired
);

   localparam int CNT_W = $clog2(HOLD_CYCLES) + 1;
   localparam logic [CNT_W-1:0] c_last = CNT_W'(HOLD_CYCLES - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_active;

   // Expiry is a pure decode of the armed count, so HOLD_CYCLES=1 expires
   // on the first cycle spent in the hold state.
   assign expired = r_active && (r_cnt == c_last);

   // Count while armed; start has priority over clear and expiry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_active <= 1'b0;
      end else if (start) begin
         r_cnt    <= '0;
         r_active <= 1'b1;
      end else if (clear || expired) begin
         r_active <= 1'b0;
      end else if (r_active) begin
         r_cnt    <= r_cnt + CNT_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/mario_game_stats.sv
`default_nettype none
// ============================================================================
//  Module      : mario_game_stats
//  Description : Gameplay counters (lives, level, coins) and game-flow FSM
//                feeding the HUD. Emits respawn / level_load pulses back to
//                the game logic. All outputs are registered.
//  Options     : MARIO_COIN_1UP_EN - every 100 coins collected grants a life.
//  Revision    : 1.0 - initial release
// ============================================================================
module mario_game_stats
   import mario_pkg::*;
#(
   parameter int START_LIVES = 3,
   parameter int MAX_LIVES   = 9,
   parameter int START_LEVEL = 1,
   parameter int MAX_LEVEL   = 9,
   parameter int COIN_MAX    = 999,
   parameter int HOLD_CYCLES = 65000000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               coin_evt,
   input  logic               death_evt,
   input  logic               level_done_evt,
   input  logic               new_game,
   output logic [LIVES_W-1:0] mario_lives,
   output logic [LEVEL_W-1:0] level,
   output logic [COINS_W-1:0] coins,
   output logic               respawn,
   output logic               level_load,
   output logic               game_over,
   output logic               game_won
);

   localparam logic [LIVES_W-1:0] c_start_lives = LIVES_W'(clamp_max(START_LIVES, MAX_LIVES));
   localparam logic [LEVEL_W-1:0] c_start_level = LEVEL_W'(START_LEVEL);
   localparam logic [LEVEL_W-1:0] c_max_level   = LEVEL_W'(MAX_LEVEL);
   localparam logic [COINS_W-1:0] c_coin_max    = COINS_W'(COIN_MAX);

   state_t             r_state,      w_state_nxt;
   logic [LIVES_W-1:0] r_lives,      w_lives_nxt;
   logic [LEVEL_W-1:0] r_level,      w_level_nxt;
   logic [COINS_W-1:0] r_coins,      w_coins_nxt;
   logic               r_respawn,    w_respawn_nxt;
   logic               r_level_load, w_level_load_nxt;
   logic               r_game_over,  w_game_over_nxt;
   logic               r_game_won,   w_game_won_nxt;
   logic               w_timer_start;
   logic               w_timer_clear;
   logic               w_expired;

`ifdef MARIO_COIN_1UP_EN
   localparam logic [LIVES_W-1:0] c_max_lives = LIVES_W'(MAX_LIVES);
   localparam logic [6:0]         c_sub_last  = 7'(COINS_PER_LIFE - 1);
   logic [6:0] r_sub, w_sub_nxt;
`endif

   // Timer is only meaningful in the pause states; disarm it elsewhere
   assign w_timer_clear = (r_state == PLAY) || (r_state == GAME_OVER);

   mario_hold_timer #(
      .HOLD_CYCLES (HOLD_CYCLES)
   ) u_hold_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (w_timer_start),
      .clear   (w_timer_clear),
      .expired (w_expired)
   );

   // Next-state and next-counter decode; pulses default low every cycle
   always_comb begin
      w_state_nxt      = r_state;
      w_lives_nxt      = r_lives;
      w_level_nxt      = r_level;
      w_coins_nxt      = r_coins;
      w_respawn_nxt    = 1'b0;
      w_level_load_nxt = 1'b0;
      w_game_over_nxt  = r_game_over;
      w_game_won_nxt   = r_game_won;
      w_timer_start    = 1'b0;
`ifdef MARIO_COIN_1UP_EN
      w_sub_nxt        = r_sub;
`endif
      case (r_state)
         PLAY: begin
            // death beats level_done beats coin; losers are dropped
            if (death_evt) begin
               if (r_lives != '0) w_lives_nxt = r_lives - LIVES_W'(1);
               w_state_nxt   = DYING;
               w_timer_start = 1'b1;
            end else if (level_done_evt) begin
               w_state_nxt   = LEVEL_DONE;
               w_timer_start = 1'b1;
            end else if (coin_evt) begin
               if (r_coins < c_coin_max) w_coins_nxt = r_coins + COINS_W'(1);
`ifdef MARIO_COIN_1UP_EN
               // sub-counter keeps running even when coins has saturated
               if (r_sub == c_sub_last) begin
                  w_sub_nxt = '0;
                  if (r_lives < c_max_lives) w_lives_nxt = r_lives + LIVES_W'(1);
               end else begin
                  w_sub_nxt = r_sub + 7'd1;
               end
`endif
            end
         end
         DYING: begin
            if (w_expired) begin
               if (r_lives == '0) begin
                  w_state_nxt     = GAME_OVER;
                  w_game_over_nxt = 1'b1;
                  w_game_won_nxt  = 1'b0;
               end else begin
                  w_state_nxt     = PLAY;
                  w_respawn_nxt   = 1'b1;
               end
            end
         end
         LEVEL_DONE: begin
            if (w_expired) begin
               if (r_level == c_max_level) begin
                  w_state_nxt     = GAME_OVER;
                  w_game_over_nxt = 1'b1;
                  w_game_won_nxt  = 1'b1;
               end else begin
                  w_level_nxt      = r_level + LEVEL_W'(1);
                  w_level_load_nxt = 1'b1;
                  w_state_nxt      = PLAY;
               end
            end
         end
         GAME_OVER: begin
            if (new_game) begin
               w_lives_nxt      = c_start_lives;
               w_level_nxt      = c_start_level;
               w_coins_nxt      = '0;
               w_game_over_nxt  = 1'b0;
               w_game_won_nxt   = 1'b0;
               w_level_load_nxt = 1'b1;
               w_state_nxt      = PLAY;
`ifdef MARIO_COIN_1UP_EN
               w_sub_nxt        = '0;
`endif
            end
         end
         default: w_state_nxt = PLAY;
      endcase
   end

   // State and output registers; async reset aborts any pause with no pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= PLAY;
         r_lives      <= c_start_lives;
         r_level      <= c_start_level;
         r_coins      <= '0;
         r_respawn    <= 1'b0;
         r_level_load <= 1'b0;
         r_game_over  <= 1'b0;
         r_game_won   <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_lives      <= w_lives_nxt;
         r_level      <= w_level_nxt;
         r_coins      <= w_coins_nxt;
         r_respawn    <= w_respawn_nxt;
         r_level_load <= w_level_load_nxt;
         r_game_over  <= w_game_over_nxt;
         r_game_won   <= w_game_won_nxt;
      end
   end

`ifdef MARIO_COIN_1UP_EN
   // Coins-toward-next-life sub-counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_sub <= '0;
      else        r_sub <= w_sub_nxt;
   end
`endif

   assign mario_lives = r_lives;
   assign level       = r_level;
   assign coins       = r_coins;
   assign respawn     = r_respawn;
   assign level_load  = r_level_load;
   assign game_over   = r_game_over;
   assign game_won    = r_game_won;

endmodule
`default_nettype wire

// File: tb/tb_mario_game_stats.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mario_game_stats
//  Description : Self-checking bench for mario_game_stats with HOLD_CYCLES=4.
//                A rules-level model (integers and a pause countdown) predicts
//                every output after each clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mario_game_stats;

   localparam int HOLD = 4;
   localparam int M_PLAY = 0, M_DYING = 1, M_DONE = 2, M_OVER = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       coin_evt = 1'b0, death_evt = 1'b0, level_done_evt = 1'b0, new_game = 1'b0;
   logic [3:0] mario_lives;
   logic [3:0] level;
   logic [11:0] coins;
   logic       respawn, level_load, game_over, game_won;

   int errors = 0;
   int checks = 0;

   // reference model state
   int m_lives, m_level, m_coins, m_tally, m_mode, m_left;
   int m_respawn, m_load, m_over, m_won;

   mario_game_stats #(
      .HOLD_CYCLES (HOLD)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .coin_evt       (coin_evt),
      .death_evt      (death_evt),
      .level_done_evt (level_done_evt),
      .new_game       (new_game),
      .mario_lives    (mario_lives),
      .level          (level),
      .coins          (coins),
      .respawn        (respawn),
      .level_load     (level_load),
      .game_over      (game_over),
      .game_won       (game_won)
   );

   // free-running clock
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("lives",      16'(mario_lives), 16'(m_lives));
      chk("level",      16'(level),       16'(m_level));
      chk("coins",      16'(coins),       16'(m_coins));
      chk("respawn",    16'(respawn),     16'(m_respawn));
      chk("level_load", 16'(level_load),  16'(m_load));
      chk("game_over",  16'(game_over),   16'(m_over));
      chk("game_won",   16'(game_won),    16'(m_won));
   endtask

   task automatic model_reset();
      m_lives = 3; m_level = 1; m_coins = 0; m_tally = 0;
      m_mode = M_PLAY; m_left = 0;
      m_respawn = 0; m_load = 0; m_over = 0; m_won = 0;
   endtask

   // One clock of game rules applied to the events seen at that edge
   task automatic model_step(input bit c, input bit d, input bit l, input bit n);
      m_respawn = 0;
      m_load    = 0;
      case (m_mode)
         M_PLAY: begin
            if (d) begin
               if (m_lives > 0) m_lives--;
               m_mode = M_DYING; m_left = HOLD;
            end else if (l) begin
               m_mode = M_DONE; m_left = HOLD;
            end else if (c) begin
               if (m_coins < 999) m_coins++;
`ifdef MARIO_COIN_1UP_EN
               m_tally++;
               if (m_tally % 100 == 0 && m_lives < 9) m_lives++;
`endif
            end
         end
         M_DYING: begin
            m_left--;
            if (m_left == 0) begin
               if (m_lives == 0) begin m_mode = M_OVER; m_over = 1; m_won = 0; end
               else begin m_respawn = 1; m_mode = M_PLAY; end
            end
         end
         M_DONE: begin
            m_left--;
            if (m_left == 0) begin
               if (m_level == 9) begin m_mode = M_OVER; m_over = 1; m_won = 1; end
               else begin m_level++; m_load = 1; m_mode = M_PLAY; end
            end
         end
         default: begin
            if (n) begin
               m_lives = 3; m_level = 1; m_coins = 0; m_tally = 0;
               m_over = 0; m_won = 0; m_load = 1; m_mode = M_PLAY;
            end
         end
      endcase
   endtask

   task automatic step(input bit c, input bit d, input bit l, input bit n);
      @(negedge clk);
      coin_evt = c; death_evt = d; level_done_evt = l; new_game = n;
      @(posedge clk);
      model_step(c, d, l, n);
      #1;
      check_all();
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) step(0, 0, 0, 0);
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();                         // reset values
      @(negedge clk);
      rst_n = 1'b1;

      // five coins, no pulses
      for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
      idle(2);

      // coin saturation (1UP build also exercises the 100-coin boundary)
      for (int i = 0; i < 993; i++) step(1, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0);

      // death with coin during DYING (ignored), respawn after the pause
      step(0, 1, 0, 0);
      step(1, 0, 0, 0);
      idle(HOLD + 1);

      // burn lives down to one
      for (int g = 0; g < 20 && m_lives > 1; g++) begin
         step(0, 1, 0, 0);
         idle(HOLD + 1);
      end

      // death and coin together: death wins, coin dropped, then game over
      step(1, 1, 0, 0);
      idle(HOLD + 2);
      step(1, 0, 1, 0);                    // ignored in GAME_OVER
      step(0, 0, 0, 1);                    // new game
      idle(1);

      // new_game outside GAME_OVER is ignored
      step(0, 0, 0, 1);

      // clear all levels, finishing with a win
      for (int g = 0; g < 12 && m_level < 9; g++) begin
         step(0, 0, 1, 0);
         idle(HOLD + 1);
      end
      step(1, 0, 1, 0);                    // level_done beats coin
      idle(HOLD + 2);
      step(0, 0, 0, 1);
      idle(1);

      // randomized play
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 2) == 0, $urandom_range(0, 24) == 0,
              $urandom_range(0, 29) == 0, $urandom_range(0, 5) == 0);
      end

      // bring the game back to PLAY, then reset mid LEVEL_DONE
      for (int g = 0; g < 20 && m_mode != M_PLAY; g++) step(0, 0, 0, 1);
      step(0, 0, 1, 0);
      idle(2);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all();                         // asynchronous clear, mid-cycle
      repeat (2) @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
      rst_n = 1'b1;
      idle(HOLD + 4);                      // no stray level_load

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
